// File: rtl/btn_event_pkg.sv
// Shared types and defaults for the button event decoder.
// FSM state encoding plus default long-press and double-press window lengths.
package btn_event_pkg;

    localparam int DEFAULT_LONG_COUNT    = 8;
    localparam int DEFAULT_DBL_GAP_COUNT = 4;

    typedef enum logic [2:0] {
        ST_IDLE           = 3'd0,
        ST_PRESSED        = 3'd1,
        ST_LONG_HELD      = 3'd2,
        ST_WAIT_SECOND    = 3'd3,
        ST_SECOND_PRESSED = 3'd4
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_event_timer.sv
// Saturating sample counter with synchronous clear and a terminal-value match flag.
// Match is combinational on the current count; the count never wraps.
module btn_event_timer
    import btn_event_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] term,
    output logic         match
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

    assign match = (count == term);

endmodule

// File: rtl/button_event_decoder.sv
// Decodes a debounced button level into press/release/short/long/double events; all outputs registered.
// Optional 2-flop input synchronizer when BTN_EVENT_SYNC_EN is defined (adds 2 cycles of latency).
module button_event_decoder
    import btn_event_pkg::*;
#(
    parameter int LONG_COUNT    = DEFAULT_LONG_COUNT,
    parameter int DBL_GAP_COUNT = DEFAULT_DBL_GAP_COUNT
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_press,
    output logic long_press,
    output logic double_press,
    output logic held
);

    localparam int CW = $clog2(max_int(LONG_COUNT, DBL_GAP_COUNT) + 1);
    localparam logic [CW-1:0] LONG_TERM = CW'(LONG_COUNT - 1);
    localparam logic [CW-1:0] GAP_TERM  = CW'(DBL_GAP_COUNT - 1);

    logic   level;
    logic   prev;
    logic   rise;
    logic   fall;
    state_t state;
    state_t state_n;
    logic   clr;
    logic   en;
    logic   match;
    logic   p_n, r_n, s_n, l_n, d_n;

`ifdef BTN_EVENT_SYNC_EN
    logic [1:0] sync;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync <= 2'b11;
        else        sync <= {sync[0], btn_level};
    end
    assign level = sync[1];
`else
    assign level = btn_level;
`endif

    // Resetting to 1 means a button already held at reset release needs a low sample before it counts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) prev <= 1'b1;
        else        prev <= level;
    end

    assign rise = level & ~prev;
    assign fall = ~level & prev;

    btn_event_timer #(.W(CW)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (clr),
        .enable (en),
        .term   ((state == ST_WAIT_SECOND) ? GAP_TERM : LONG_TERM),
        .match  (match)
    );

    // Edge events are checked before the timer match so they win on the boundary edge.
    always_comb begin
        state_n = state;
        clr     = 1'b0;
        en      = 1'b0;
        p_n     = 1'b0;
        r_n     = 1'b0;
        s_n     = 1'b0;
        l_n     = 1'b0;
        d_n     = 1'b0;
        case (state)
            ST_IDLE: begin
                clr = 1'b1;
                if (rise) begin
                    state_n = ST_PRESSED;
                    p_n     = 1'b1;
                end
            end
            ST_PRESSED: begin
                if (fall) begin
                    state_n = ST_WAIT_SECOND;
                    clr     = 1'b1;
                    r_n     = 1'b1;
                end else if (match) begin
                    state_n = ST_LONG_HELD;
                    l_n     = 1'b1;
                end else begin
                    en = 1'b1;
                end
            end
            ST_LONG_HELD: begin
                clr = 1'b1;
                if (fall) begin
                    state_n = ST_IDLE;
                    r_n     = 1'b1;
                end
            end
            ST_WAIT_SECOND: begin
                if (rise) begin
                    state_n = ST_SECOND_PRESSED;
                    clr     = 1'b1;
                    p_n     = 1'b1;
                    d_n     = 1'b1;
                end else if (match) begin
                    state_n = ST_IDLE;
                    s_n     = 1'b1;
                end else begin
                    en = 1'b1;
                end
            end
            ST_SECOND_PRESSED: begin
                clr = 1'b1;
                if (fall) begin
                    state_n = ST_IDLE;
                    r_n     = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                clr     = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_press   <= 1'b0;
            long_press    <= 1'b0;
            double_press  <= 1'b0;
            held          <= 1'b0;
        end else begin
            state         <= state_n;
            press_pulse   <= p_n;
            release_pulse <= r_n;
            short_press   <= s_n;
            long_press    <= l_n;
            double_press  <= d_n;
            held          <= (state_n == ST_PRESSED) || (state_n == ST_LONG_HELD) ||
                             (state_n == ST_SECOND_PRESSED);
        end
    end

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with default parameters and no input synchronizer.
// Output vector order: {press, release, short, long, double, held}.
module tb_button_event_decoder;

    logic clk = 1'b0;
    logic reset;
    logic btn_level;
    logic press_pulse, release_pulse, short_press, long_press, double_press, held;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       btn;
        int         reps;
        logic       held_mid;
        logic [5:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[$];

    button_event_decoder dut (
        .clk           (clk),
        .reset         (reset),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .short_press   (short_press),
        .long_press    (long_press),
        .double_press  (double_press),
        .held          (held)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] outs();
        return {press_pulse, release_pulse, short_press, long_press, double_press, held};
    endfunction

    task automatic check(input logic [5:0] exp, input string name);
        checks++;
        if (outs() !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, outs(), exp);
        end
    endtask

    task automatic step(input logic b, input logic [5:0] exp, input string name);
        @(negedge clk);
        btn_level = b;
        @(posedge clk);
        #1;
        check(exp, name);
    endtask

    task automatic add(input logic b, input int r, input logic h, input logic [5:0] e, input string n);
        vec_t v;
        v.btn = b; v.reps = r; v.held_mid = h; v.exp = e; v.name = n;
        vecs.push_back(v);
    endtask

    initial begin
        // long press: press edge 10, long at 18, release at 25
        add(1'b0, 9,  1'b0, 6'b000000, "long_idle");
        add(1'b1, 1,  1'b0, 6'b100001, "long_press_edge");
        add(1'b1, 7,  1'b1, 6'b000001, "long_holding");
        add(1'b1, 1,  1'b1, 6'b000101, "long_threshold");
        add(1'b1, 6,  1'b1, 6'b000001, "long_held");
        add(1'b0, 1,  1'b0, 6'b010000, "long_release");
        add(1'b0, 8,  1'b0, 6'b000000, "long_after");
        // short press: press 10, release 13, short at 17
        add(1'b1, 1,  1'b0, 6'b100001, "short_press_edge");
        add(1'b1, 2,  1'b1, 6'b000001, "short_holding");
        add(1'b0, 1,  1'b0, 6'b010000, "short_release");
        add(1'b0, 3,  1'b0, 6'b000000, "short_gap");
        add(1'b0, 1,  1'b0, 6'b001000, "short_expiry");
        add(1'b0, 6,  1'b0, 6'b000000, "short_after");
        // double press: press 10, release 13, press 15, release 40
        add(1'b1, 1,  1'b0, 6'b100001, "dbl_first_press");
        add(1'b1, 2,  1'b1, 6'b000001, "dbl_holding");
        add(1'b0, 1,  1'b0, 6'b010000, "dbl_first_release");
        add(1'b0, 1,  1'b0, 6'b000000, "dbl_gap");
        add(1'b1, 1,  1'b0, 6'b100011, "dbl_second_press");
        add(1'b1, 24, 1'b1, 6'b000001, "dbl_second_held");
        add(1'b0, 1,  1'b0, 6'b010000, "dbl_second_release");
        add(1'b0, 8,  1'b0, 6'b000000, "dbl_after");
        // release on long-threshold edge, press on gap-expiry edge
        add(1'b1, 1,  1'b0, 6'b100001, "edge_press");
        add(1'b1, 7,  1'b1, 6'b000001, "edge_holding");
        add(1'b0, 1,  1'b0, 6'b010000, "edge_release_wins");
        add(1'b0, 3,  1'b0, 6'b000000, "edge_gap");
        add(1'b1, 1,  1'b0, 6'b100011, "edge_press_wins");
        add(1'b0, 1,  1'b0, 6'b010000, "edge_second_release");
        add(1'b0, 8,  1'b0, 6'b000000, "edge_after");

        reset     = 1'b0;
        btn_level = 1'b0;
        #23;
        check(6'b000000, "reset_state");
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            for (int k = 1; k < vecs[i].reps; k++)
                step(vecs[i].btn, {5'b00000, vecs[i].held_mid}, vecs[i].name);
            step(vecs[i].btn, vecs[i].exp, vecs[i].name);
        end

        // level already high when reset releases: no press until a low sample is seen
        @(negedge clk);
        reset     = 1'b0;
        btn_level = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 10; k++) step(1'b1, 6'b000000, "high_at_reset");
        step(1'b0, 6'b000000, "high_at_reset_fall");
        step(1'b1, 6'b100001, "after_reset_press");
        step(1'b1, 6'b000001, "after_reset_held");

        // async reset while pressed aborts everything
        #2;
        reset = 1'b0;
        #1;
        check(6'b000000, "reset_mid_press");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 10; k++) step(1'b1, 6'b000000, "post_reset_high");
        for (int k = 0; k < 6; k++)  step(1'b0, 6'b000000, "post_reset_low");

        // normal operation resumes
        step(1'b1, 6'b100001, "resume_press");
        step(1'b0, 6'b010000, "resume_release");
        for (int k = 0; k < 3; k++) step(1'b0, 6'b000000, "resume_gap");
        step(1'b0, 6'b001000, "resume_short");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_event_decoder.md
BUTTON_EVENT_DECODER -- requirements
Module: button_event_decoder

Interface
REQ-001 Parameter LONG_COUNT, default 8: consecutive high samples after a press that qualify as a long press; must be >= 2.
REQ-002 Parameter DBL_GAP_COUNT, default 4: maximum low samples after a release within which a new press counts as a double press; must be >= 2.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 btn_level  input  1  debounced button level from button_conditioner.out; 1 = pressed.
REQ-006 press_pulse  output  1  one-cycle pulse on each press.
REQ-007 release_pulse  output  1  one-cycle pulse on each release.
REQ-008 short_press  output  1  one-cycle pulse: single short press completed.
REQ-009 long_press  output  1  one-cycle pulse: long-press threshold reached.
REQ-010 double_press  output  1  one-cycle pulse: second press within the gap window.
REQ-011 held  output  1  level, high while the FSM is in any pressed state.

Function
REQ-012 All outputs SHALL be registered; each event pulse is high for exactly one cycle, in the cycle after the edge that samples the event.
REQ-013 Edge detection SHALL compare btn_level with a registered previous sample; a press is a 0-to-1 change, a release is a 1-to-0 change.
REQ-014 FSM states: IDLE, PRESSED, LONG_HELD, WAIT_SECOND, SECOND_PRESSED.
REQ-015 IDLE: on a press -> PRESSED, clear counter, press_pulse.
REQ-016 PRESSED (press sampled at edge N): release at any edge N+1..N+LONG_COUNT -> WAIT_SECOND, clear counter, release_pulse; level high through edge N+LONG_COUNT -> LONG_HELD, long_press.
REQ-017 LONG_HELD: on release -> IDLE, release_pulse; no short_press or double_press.
REQ-018 WAIT_SECOND (release sampled at edge M): press at any edge M+1..M+DBL_GAP_COUNT -> SECOND_PRESSED, press_pulse and double_press in the same cycle; level low through edge M+DBL_GAP_COUNT -> IDLE, short_press.
REQ-019 SECOND_PRESSED: on release -> IDLE, release_pulse; long-press timing is not applied.
REQ-020 Simultaneity: a release on the long-threshold edge wins (no long_press); a press on the gap-expiry edge wins (double_press, no short_press).
REQ-021 The counter width SHALL be $clog2(max(LONG_COUNT, DBL_GAP_COUNT)+1) and the counter SHALL saturate, never wrap.
REQ-022 held SHALL be high exactly in PRESSED, LONG_HELD and SECOND_PRESSED.

Reset
REQ-023 While reset is low: state IDLE, counter 0, all outputs 0, previous-sample register 1.
REQ-024 The previous sample resets to 1 so a level already high at reset release produces no press; a low sample is required first.
REQ-025 Reset mid-operation SHALL abort any pending event with no pulse emitted.

Configuration
REQ-026 Macro BTN_EVENT_SYNC_EN defined: btn_level SHALL pass through a 2-flop synchronizer (reset value 1) before edge detection, adding exactly 2 cycles to every event latency.
REQ-027 Macro BTN_EVENT_SYNC_EN undefined: btn_level SHALL feed edge detection directly; timing is as in REQ-012.

Structure
REQ-028 Package btn_event_pkg SHALL hold the FSM state enum typedef and the default LONG_COUNT/DBL_GAP_COUNT constants.
REQ-029 Sub-module btn_event_timer (clear, enable, saturating count, terminal-match output) SHALL implement the shared counter.

Verification (LONG_COUNT=8, DBL_GAP_COUNT=4, macro undefined)
REQ-030 Press at edge 10, held through edge 18 -> press_pulse after edge 10, long_press after edge 18, held 1; release at 25 -> release_pulse only.
REQ-031 Press at 10, release at 13, low through 17 -> release_pulse after 13, short_press after 17, no double_press.
REQ-032 Press at 10, release at 13, press at 15 -> press_pulse and double_press after 15; release at 40 -> release_pulse, no long_press.
REQ-033 Release on edge 18 of a press sampled at edge 10 -> release_pulse, no long_press; press on edge M+4 after release at edge M -> double_press, no short_press.
REQ-034 btn_level high while reset deasserts, then held -> no pulses; reset asserted during PRESSED -> all outputs 0, no pulses.
REQ-035 BTN_EVENT_SYNC_EN defined, REQ-030 stimulus -> press_pulse after edge 12, long_press after edge 20.
